people_move_control: RTL and testbench
======================================

Name: people_move_control

Overview:
- Player-side counterpart to the ghost hazard controllers.
- Moves the person sprite (people_up / people_left) one STEP per decoded movement-key press, clamped to the playfield.
- Responds to the sticky `fail` level raised by the ghost controllers: a blink/death sequence, then a lives decrement and respawn.
- Respawn issues a one-cycle `ghost_rst` pulse so the ghost controllers clear `fail`. When lives run out, the block locks in game-over.

Parameters:
- START_UP, 330, reset/respawn vertical position (pixels)
- START_LEFT, 250, reset/respawn horizontal position (pixels)
- STEP, 10, pixels moved per accepted key press
- MIN_UP, 40, smallest legal people_up
- MAX_UP, 440, largest legal people_up
- MIN_LEFT, 40, smallest legal people_left
- MAX_LEFT, 600, largest legal people_left
- LIVES, 3, initial life count (1..7)
- TICK_CYCLES, 10_000_000, clk cycles per animation tick
- DIE_TICKS, 10, ticks spent in DYING

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- key_valid  in  1  one-cycle pulse: key_code holds a newly pressed key
- key_code  in  9  keyboard scan code
- fail  in  1  OR of ghost fail outputs; level, stays high until ghosts are reset
- people_up  out  10  sprite top coordinate
- people_left  out  10  sprite left coordinate
- dir  out  2  facing: 0 left, 1 right, 2 up, 3 down
- visible  out  1  sprite draw enable (blinks while dying)
- lives  out  3  remaining lives
- ghost_rst  out  1  one-cycle pulse; OR'd into the ghost controllers' rst
- game_over  out  1  sticky end-of-game flag

Behaviour:
- Reset values: people_up=START_UP, people_left=START_LEFT, dir=1, visible=1, lives=LIVES, ghost_rst=0, game_over=0, state=PLAY, tick counter=0, die count=0.
- States: PLAY, DYING, RESPAWN, OVER.
- Key map:
  - 9'h01C (A) / 9'h005 → left
  - 9'h023 (D) / 9'h006 → right
  - 9'h01D (W) / 9'h004 → up
  - 9'h01B (S) / 9'h00C → down
  - Any other code: no effect.
- PLAY, key_valid with a mapped code and fail=0 → on the next edge dir takes the key direction and the position moves by STEP. Latency 1 cycle.
- Clamping, with compare done at 11 bits so there is no wrap:
  - left: people_left <= MIN_LEFT+STEP ? MIN_LEFT : people_left-STEP
  - right: people_left+STEP >= MAX_LEFT ? MAX_LEFT : people_left+STEP
  - up / down: same rule on people_up with MIN_UP / MAX_UP.
  - At a bound, dir still updates.
- PLAY, fail=1 → DYING next edge. The tick counter and die count clear; a key press in the same cycle is ignored (fail wins).
- DYING:
  - Tick counter counts 0..TICK_CYCLES-1; each wrap is one tick.
  - Each tick toggles visible and increments die count.
  - When die count reaches DIE_TICKS:
    - lives==1 → OVER with lives=0, game_over=1, visible=1, no ghost_rst.
    - lives>1 → lives-1, position=START, dir=1, visible=1, ghost_rst=1 for exactly one cycle, state RESPAWN.
- RESPAWN: stay while fail=1; when fail=0 → PLAY next edge. ghost_rst is never asserted for more than one cycle.
- OVER: absorbing. Only rst leaves it.
- In DYING, RESPAWN and OVER, key_valid is ignored.
- rst in any state, including mid-DYING, restores all reset values on the next edge. ghost_rst does not go high as a result of rst.
- Tick counter runs only in DYING; it holds 0 in the other states.

Test Plan:
(Bench parameters: TICK_CYCLES=4, DIE_TICKS=3, LIVES=2.)
- rst, then key_valid with 9'h023 → after 1 cycle people_left=260, dir=1; 36 further D presses → people_left saturates at 600, never exceeds it.
- 30 presses of 9'h01D from people_up=330 → people_up clamps at 40 with dir=2; code 9'h0FF → no change.
- fail=1 in the same cycle as an A press → position unchanged. Over 12 cycles visible toggles 3 times. Then ghost_rst is high for 1 cycle, lives=1, position (330,250), dir=1.
- Hold fail high for 3 cycles after the ghost_rst pulse → state stays RESPAWN and keys are ignored. Drop fail → moves accepted again one cycle later.
- Second fail → after 12 cycles lives=0, game_over=1, ghost_rst stays 0; keys ignored for 100 cycles.
- Assert rst mid-DYING → next edge lives=2, visible=1, game_over=0, no ghost_rst pulse.

Source files
------------

// File: rtl/people_move_control.sv
// Player sprite controller: key-driven movement clamped to the playfield, blink/death
// sequence on ghost contact, lives bookkeeping, respawn with a ghost reset pulse, game over.
module people_move_control #(
    parameter int START_UP    = 330,
    parameter int START_LEFT  = 250,
    parameter int STEP        = 10,
    parameter int MIN_UP      = 40,
    parameter int MAX_UP      = 440,
    parameter int MIN_LEFT    = 40,
    parameter int MAX_LEFT    = 600,
    parameter int LIVES       = 3,
    parameter int TICK_CYCLES = 10_000_000,
    parameter int DIE_TICKS   = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_valid,
    input  logic [8:0] key_code,
    input  logic       fail,
    output logic [9:0] people_up,
    output logic [9:0] people_left,
    output logic [1:0] dir,
    output logic       visible,
    output logic [2:0] lives,
    output logic       ghost_rst,
    output logic       game_over
);
    localparam int TW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam int DW = $clog2(DIE_TICKS + 1);

    localparam logic [TW-1:0] TICK_LAST    = TW'(TICK_CYCLES - 1);
    localparam logic [DW-1:0] DIE_LAST     = DW'(DIE_TICKS);
    localparam logic [9:0]    START_UP_C   = 10'(START_UP);
    localparam logic [9:0]    START_LEFT_C = 10'(START_LEFT);
    localparam logic [9:0]    MIN_UP_C     = 10'(MIN_UP);
    localparam logic [9:0]    MAX_UP_C     = 10'(MAX_UP);
    localparam logic [9:0]    MIN_LEFT_C   = 10'(MIN_LEFT);
    localparam logic [9:0]    MAX_LEFT_C   = 10'(MAX_LEFT);
    localparam logic [2:0]    LIVES_C      = 3'(LIVES);

    localparam logic [1:0] DIR_LEFT  = 2'd0;
    localparam logic [1:0] DIR_RIGHT = 2'd1;
    localparam logic [1:0] DIR_UP    = 2'd2;
    localparam logic [1:0] DIR_DOWN  = 2'd3;

    typedef enum logic [1:0] {
        PLAY    = 2'd0,
        DYING   = 2'd1,
        RESPAWN = 2'd2,
        OVER    = 2'd3
    } state_t;

    state_t          state_r, state_s;
    logic [9:0]      up_r, up_s;
    logic [9:0]      left_r, left_s;
    logic [1:0]      dir_r, dir_s;
    logic            visible_r, visible_s;
    logic [2:0]      lives_r, lives_s;
    logic            ghost_rst_r, ghost_rst_s;
    logic            game_over_r, game_over_s;
    logic [TW-1:0]   tick_r, tick_s;
    logic [DW-1:0]   die_r, die_s;
    logic            key_hit_s;
    logic [1:0]      key_dir_s;

    // Returns {hit, direction}; unmapped codes give hit=0.
    function automatic logic [2:0] decode_key(input logic [8:0] code);
        logic [2:0] res;
        case (code)
            9'h01C, 9'h005: res = {1'b1, DIR_LEFT};
            9'h023, 9'h006: res = {1'b1, DIR_RIGHT};
            9'h01D, 9'h004: res = {1'b1, DIR_UP};
            9'h01B, 9'h00C: res = {1'b1, DIR_DOWN};
            default:        res = 3'b000;
        endcase
        return res;
    endfunction

    // Comparisons are widened to 11 bits so a step past either bound cannot wrap.
    function automatic logic [9:0] step_dec(input logic [9:0] pos, input logic [9:0] lo);
        logic [9:0] res;
        if ({1'b0, pos} <= ({1'b0, lo} + 11'(STEP))) begin
            res = lo;
        end else begin
            res = pos - 10'(STEP);
        end
        return res;
    endfunction

    function automatic logic [9:0] step_inc(input logic [9:0] pos, input logic [9:0] hi);
        logic [9:0] res;
        if (({1'b0, pos} + 11'(STEP)) >= {1'b0, hi}) begin
            res = hi;
        end else begin
            res = pos + 10'(STEP);
        end
        return res;
    endfunction

    assign {key_hit_s, key_dir_s} = decode_key(key_code);

    // Next-state and next-output logic for the play / death / respawn sequence.
    always_comb begin
        state_s     = state_r;
        up_s        = up_r;
        left_s      = left_r;
        dir_s       = dir_r;
        visible_s   = visible_r;
        lives_s     = lives_r;
        ghost_rst_s = 1'b0;
        game_over_s = game_over_r;
        tick_s      = '0;
        die_s       = die_r;
        case (state_r)
            PLAY: begin
                if (fail) begin
                    state_s = DYING;
                    die_s   = '0;
                end else if (key_valid && key_hit_s) begin
                    dir_s = key_dir_s;
                    case (key_dir_s)
                        DIR_LEFT:  left_s = step_dec(left_r, MIN_LEFT_C);
                        DIR_RIGHT: left_s = step_inc(left_r, MAX_LEFT_C);
                        DIR_UP:    up_s   = step_dec(up_r, MIN_UP_C);
                        DIR_DOWN:  up_s   = step_inc(up_r, MAX_UP_C);
                        default:   up_s   = up_r;
                    endcase
                end else begin
                    dir_s = dir_r;
                end
            end
            DYING: begin
                // The final tick is shown for one cycle before the sequence resolves.
                if (die_r == DIE_LAST) begin
                    visible_s = 1'b1;
                    if (lives_r == 3'd1) begin
                        state_s     = OVER;
                        lives_s     = 3'd0;
                        game_over_s = 1'b1;
                    end else begin
                        state_s     = RESPAWN;
                        lives_s     = lives_r - 3'd1;
                        up_s        = START_UP_C;
                        left_s      = START_LEFT_C;
                        dir_s       = DIR_RIGHT;
                        ghost_rst_s = 1'b1;
                    end
                end else if (tick_r == TICK_LAST) begin
                    visible_s = ~visible_r;
                    die_s     = die_r + DW'(1);
                end else begin
                    tick_s = tick_r + TW'(1);
                end
            end
            RESPAWN: begin
                if (fail) begin
                    state_s = RESPAWN;
                end else begin
                    state_s = PLAY;
                end
            end
            OVER: begin
                state_s = OVER;
            end
            default: begin
                state_s = PLAY;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= PLAY;
            up_r        <= START_UP_C;
            left_r      <= START_LEFT_C;
            dir_r       <= DIR_RIGHT;
            visible_r   <= 1'b1;
            lives_r     <= LIVES_C;
            ghost_rst_r <= 1'b0;
            game_over_r <= 1'b0;
            tick_r      <= '0;
            die_r       <= '0;
        end else begin
            state_r     <= state_s;
            up_r        <= up_s;
            left_r      <= left_s;
            dir_r       <= dir_s;
            visible_r   <= visible_s;
            lives_r     <= lives_s;
            ghost_rst_r <= ghost_rst_s;
            game_over_r <= game_over_s;
            tick_r      <= tick_s;
            die_r       <= die_s;
        end
    end

    assign people_up   = up_r;
    assign people_left = left_r;
    assign dir         = dir_r;
    assign visible     = visible_r;
    assign lives       = lives_r;
    assign ghost_rst   = ghost_rst_r;
    assign game_over   = game_over_r;

endmodule

// File: tb/tb_people_move_control.sv
// Bench for people_move_control: directed scenarios with literal expectations plus a
// randomized phase, all outputs compared every cycle against a behavioural model.
module tb_people_move_control;
    localparam int T  = 4;
    localparam int D  = 3;
    localparam int L  = 2;
    localparam int SU = 330;
    localparam int SL = 250;
    localparam int ST = 10;
    localparam int MINU = 40;
    localparam int MAXU = 440;
    localparam int MINL = 40;
    localparam int MAXL = 600;

    logic       clk;
    logic       rst;
    logic       key_valid;
    logic [8:0] key_code;
    logic       fail;
    logic [9:0] people_up;
    logic [9:0] people_left;
    logic [1:0] dir;
    logic       visible;
    logic [2:0] lives;
    logic       ghost_rst;
    logic       game_over;

    int n_chk = 0;
    int n_fail = 0;
    bit chk_en = 0;

    people_move_control #(
        .TICK_CYCLES(T),
        .DIE_TICKS(D),
        .LIVES(L)
    ) dut (
        .clk(clk),
        .rst(rst),
        .key_valid(key_valid),
        .key_code(key_code),
        .fail(fail),
        .people_up(people_up),
        .people_left(people_left),
        .dir(dir),
        .visible(visible),
        .lives(lives),
        .ghost_rst(ghost_rst),
        .game_over(game_over)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // mode: 0 play, 1 dying, 2 respawn, 3 over; dc = cycles elapsed since dying began
    typedef struct packed {
        int up; int left; int dir; int vis; int lives; int grst; int over; int mode; int dc;
    } model_t;

    model_t m;

    function automatic int keydir(logic [8:0] c);
        case (c)
            9'h01C, 9'h005: return 0;
            9'h023, 9'h006: return 1;
            9'h01D, 9'h004: return 2;
            9'h01B, 9'h00C: return 3;
            default:        return -1;
        endcase
    endfunction

    function automatic model_t reset_model();
        model_t n;
        n.up = SU; n.left = SL; n.dir = 1; n.vis = 1; n.lives = L;
        n.grst = 0; n.over = 0; n.mode = 0; n.dc = 0;
        return n;
    endfunction

    function automatic model_t mstep(model_t s, logic r, logic kv, logic [8:0] c, logic f);
        model_t n;
        int kd;
        n = s;
        n.grst = 0;
        if (r) begin
            n = reset_model();
        end else begin
            case (s.mode)
                0: begin
                    kd = keydir(c);
                    if (f) begin
                        n.mode = 1;
                        n.dc = 0;
                    end else if (kv && kd >= 0) begin
                        n.dir = kd;
                        case (kd)
                            0: n.left = (s.left - ST < MINL) ? MINL : s.left - ST;
                            1: n.left = (s.left + ST > MAXL) ? MAXL : s.left + ST;
                            2: n.up   = (s.up - ST < MINU) ? MINU : s.up - ST;
                            default: n.up = (s.up + ST > MAXU) ? MAXU : s.up + ST;
                        endcase
                    end
                end
                1: begin
                    n.dc = s.dc + 1;
                    if (n.dc == T * D + 1) begin
                        n.vis = 1;
                        if (s.lives == 1) begin
                            n.mode = 3; n.lives = 0; n.over = 1;
                        end else begin
                            n.mode = 2; n.lives = s.lives - 1; n.grst = 1;
                            n.up = SU; n.left = SL; n.dir = 1;
                        end
                    end else begin
                        n.vis = ((n.dc / T) % 2 == 0) ? 1 : 0;
                    end
                end
                2: if (!f) n.mode = 0;
                default: n.mode = 3;
            endcase
        end
        return n;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    always @(posedge clk) m <= mstep(m, rst, key_valid, key_code, fail);

    always @(negedge clk) begin
        if (chk_en) begin
            chk("model people_up", 32'(people_up), m.up);
            chk("model people_left", 32'(people_left), m.left);
            chk("model dir", 32'(dir), m.dir);
            chk("model visible", 32'(visible), m.vis);
            chk("model lives", 32'(lives), m.lives);
            chk("model ghost_rst", 32'(ghost_rst), m.grst);
            chk("model game_over", 32'(game_over), m.over);
        end
    end

    // Caller sits on a negedge; the press is applied at the following posedge.
    task automatic press(input logic [8:0] c);
        key_valid = 1'b1;
        key_code = c;
        @(negedge clk);
        key_valid = 1'b0;
    endtask

    function automatic logic [8:0] pick_code();
        case ($urandom_range(0, 9))
            0: return 9'h01C;
            1: return 9'h005;
            2: return 9'h023;
            3: return 9'h006;
            4: return 9'h01D;
            5: return 9'h004;
            6: return 9'h01B;
            7: return 9'h00C;
            default: return 9'($urandom);
        endcase
    endfunction

    initial begin
        int toggles;
        int grst_seen;
        logic prev_vis;
        rst = 1'b1;
        key_valid = 1'b0;
        key_code = 9'h000;
        fail = 1'b0;
        @(posedge clk);
        chk_en = 1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset people_up", 32'(people_up), 330);
        chk("reset people_left", 32'(people_left), 250);
        chk("reset dir", 32'(dir), 1);
        chk("reset visible", 32'(visible), 1);
        chk("reset lives", 32'(lives), 2);
        chk("reset ghost_rst", 32'(ghost_rst), 0);
        chk("reset game_over", 32'(game_over), 0);

        press(9'h023);
        chk("first D left", 32'(people_left), 260);
        chk("first D dir", 32'(dir), 1);
        repeat (36) press(9'h023);
        chk("D saturate left", 32'(people_left), 600);

        repeat (30) press(9'h01D);
        chk("W clamp up", 32'(people_up), 40);
        chk("W clamp dir", 32'(dir), 2);
        press(9'h0FF);
        chk("unmapped up", 32'(people_up), 40);
        chk("unmapped left", 32'(people_left), 600);
        chk("unmapped dir", 32'(dir), 2);

        fail = 1'b1;
        press(9'h01C);
        chk("fail wins left", 32'(people_left), 600);
        chk("fail wins dir", 32'(dir), 2);
        toggles = 0;
        prev_vis = visible;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (visible !== prev_vis) toggles++;
            prev_vis = visible;
        end
        chk("dying toggles", 32'(toggles), 3);
        @(negedge clk);
        chk("respawn ghost_rst", 32'(ghost_rst), 1);
        chk("respawn lives", 32'(lives), 1);
        chk("respawn up", 32'(people_up), 330);
        chk("respawn left", 32'(people_left), 250);
        chk("respawn dir", 32'(dir), 1);
        chk("respawn visible", 32'(visible), 1);

        press(9'h023);
        chk("ghost_rst one cycle", 32'(ghost_rst), 0);
        press(9'h023);
        @(negedge clk);
        chk("respawn keys ignored", 32'(people_left), 250);
        fail = 1'b0;
        @(negedge clk);
        press(9'h01C);
        chk("play again left", 32'(people_left), 240);
        chk("play again dir", 32'(dir), 0);

        fail = 1'b1;
        grst_seen = 0;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            if (ghost_rst !== 1'b0) grst_seen++;
        end
        chk("over lives", 32'(lives), 0);
        chk("over game_over", 32'(game_over), 1);
        chk("over visible", 32'(visible), 1);
        chk("over no ghost_rst", 32'(grst_seen), 0);
        fail = 1'b0;
        for (int i = 0; i < 100; i++) begin
            press(pick_code());
            if (ghost_rst !== 1'b0) grst_seen++;
        end
        chk("over keys left", 32'(people_left), 240);
        chk("over keys up", 32'(people_up), 330);
        chk("over still", 32'(game_over), 1);
        chk("over no ghost_rst later", 32'(grst_seen), 0);

        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        fail = 1'b1;
        repeat (6) @(negedge clk);
        chk("mid dying visible", 32'(visible), 0);
        rst = 1'b1;
        fail = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        chk("rst dying lives", 32'(lives), 2);
        chk("rst dying visible", 32'(visible), 1);
        chk("rst dying game_over", 32'(game_over), 0);
        chk("rst dying ghost_rst", 32'(ghost_rst), 0);
        @(negedge clk);
        chk("rst dying ghost_rst after", 32'(ghost_rst), 0);

        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 299) == 0);
            key_valid = ($urandom_range(0, 2) == 0);
            key_code = pick_code();
            if (fail) fail = ($urandom_range(0, 5) != 0);
            else fail = ($urandom_range(0, 39) == 0);
            @(negedge clk);
        end
        rst = 1'b0;
        key_valid = 1'b0;
        fail = 1'b0;
        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
